// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub_pkg
// Purpose : Shared types and constants for the bit-serial subtractor.
// Revision: 1.0
// ============================================================================
package serial_sub_pkg;

  localparam int SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_sub_if.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub_if
// Purpose : Operand/result bundle between the operand source and serial_sub.
// Revision: 1.0
// ============================================================================
interface serial_sub_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
  );

endinterface
`default_nettype wire

// File: rtl/full_sub.sv
`default_nettype none
// ============================================================================
// Module  : full_sub
// Purpose : Single-bit full subtractor cell, d = a - b - bi.
// Revision: 1.0
// ============================================================================
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  logic w_x;

  assign w_x = a ^ b;
  assign d   = w_x ^ bi;
  assign bo  = (~a & b) | (~w_x & bi);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module  : serial_sub
// Purpose : Bit-serial unsigned subtractor, one bit per clock, LSB first.
// Revision: 1.0
// ============================================================================
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  serial_sub_if.slave bus
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  sub_state_t         r_state;
  sub_state_t         w_next;
  logic               w_load;
  logic               w_last;

  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   w_res_shift;
  logic               r_brw;
  logic [c_CNT_W-1:0] r_cnt;

  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_diff;
  logic               r_bout;

  logic               w_d;
  logic               w_bo;

  full_sub u_slice (
    .a  (r_sa[0]),
    .b  (r_sb[0]),
    .bi (r_brw),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last = (r_cnt == c_LAST);

  // The new difference bit enters at the MSB so the LSB lands in bit 0 last.
  generate
    if (WIDTH == 1) begin : g_one
      assign w_res_shift = w_d;
    end else begin : g_wide
      assign w_res_shift = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = RUN;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_diff <= '0;
      r_bout <= 1'b0;
    end else begin
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_load) begin
        r_sa  <= bus.a;
        r_sb  <= bus.b;
        r_res <= '0;
        r_brw <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_sa  <= r_sa >> 1;
        r_sb  <= r_sb >> 1;
        r_res <= w_res_shift;
        r_brw <= w_bo;
        r_cnt <= r_cnt + c_CNT_W'(1);
        if (w_last) begin
          r_diff <= w_res_shift;
          r_bout <= w_bo;
        end
      end
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_sub
// Purpose : Self-checking bench for serial_sub at WIDTH 1, 8 and 13.
// Revision: 1.0
// ============================================================================
module tb_serial_sub;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_sub_if #(.WIDTH(8))  bus8 ();
  serial_sub_if #(.WIDTH(1))  bus1 ();
  serial_sub_if #(.WIDTH(13)) bus13 ();

  serial_sub #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
  serial_sub #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
  serial_sub #(.WIDTH(13)) u_dut13 (.clk(clk), .rst(rst), .bus(bus13));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one WIDTH=8 job; lat is the cycle (start cycle = 0) where done is seen.
  task automatic job8(input logic [7:0] a, input logic [7:0] b, output int lat,
                      output logic [7:0] d, output logic bo, output int busy_bad);
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = a;
    bus8.b     = b;
    @(negedge clk);
    bus8.start = 1'b0;
    lat        = 1;
    busy_bad   = 0;
    while (!bus8.done && lat < 40) begin
      if (!bus8.busy) busy_bad++;
      @(negedge clk);
      lat++;
    end
    if (bus8.busy) busy_bad++;
    d  = bus8.diff;
    bo = bus8.bout;
    @(negedge clk);
    if (bus8.busy || bus8.done) busy_bad++;
  endtask

  initial begin
    int          lat;
    int          bb;
    int          dones;
    int          t1;
    int          t2;
    logic [7:0]  d;
    logic        bo;
    logic [31:0] ma;
    logic [31:0] mb;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[3] = '{8'h10, 8'h01, 8'h0F, 1'b0};
    vecs[4] = '{8'h01, 8'h10, 8'hF1, 1'b1};
    vecs[5] = '{8'h80, 8'h7F, 8'h01, 1'b0};
    vecs[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};

    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    bus1.start  = 1'b0; bus1.a  = '0; bus1.b  = '0;
    bus13.start = 1'b0; bus13.a = '0; bus13.b = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'b0, bus8.busy}, 0);
    check("rst_done", {31'b0, bus8.done}, 0);
    check("rst_diff", {24'b0, bus8.diff}, 0);
    check("rst_bout", {31'b0, bus8.bout}, 0);

    for (int i = 0; i < 8; i++) begin
      job8(vecs[i].a, vecs[i].b, lat, d, bo, bb);
      check("vec_diff", {24'b0, d}, {24'b0, vecs[i].diff});
      check("vec_bout", {31'b0, bo}, {31'b0, vecs[i].bout});
      check("vec_latency", lat, 9);
      check("vec_busy_window", bb, 0);
    end

    // start re-pulsed in cycle 4 of a running job must be ignored
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h5A; bus8.b = 8'h3C;
    dones = 0; t1 = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      bus8.start = (c == 4);
      if (c == 4) begin bus8.a = 8'h11; bus8.b = 8'h22; end
      if (bus8.done) begin
        dones++;
        if (t1 == 0) t1 = c;
      end
    end
    check("ign_done_count", dones, 1);
    check("ign_done_cycle", t1, 9);
    check("ign_diff", {24'b0, bus8.diff}, 32'h1E);
    check("ign_bout", {31'b0, bus8.bout}, 0);

    // start held high, new operands presented in each DONE cycle
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
    t1 = 0; t2 = 0;
    for (int c = 1; c <= 40 && t2 == 0; c++) begin
      @(negedge clk);
      if (bus8.done) begin
        if (t1 == 0) begin
          t1 = c;
          check("b2b_diff0", {24'b0, bus8.diff}, 32'h0F);
          check("b2b_bout0", {31'b0, bus8.bout}, 0);
          bus8.a = 8'h01; bus8.b = 8'h10;
        end else begin
          t2 = c;
          check("b2b_diff1", {24'b0, bus8.diff}, 32'hF1);
          check("b2b_bout1", {31'b0, bus8.bout}, 1);
          bus8.start = 1'b0;
        end
      end
    end
    bus8.start = 1'b0;
    check("b2b_first_cycle", t1, 9);
    check("b2b_period", t2 - t1, 9);

    // reset asserted in cycle 5 aborts the job
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h33; bus8.b = 8'h44;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, bus8.busy}, 0);
    check("abort_done", {31'b0, bus8.done}, 0);
    check("abort_diff", {24'b0, bus8.diff}, 0);
    check("abort_bout", {31'b0, bus8.bout}, 0);
    dones = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) dones++;
    end
    check("abort_no_done", dones, 0);
    job8(8'h5A, 8'h3C, lat, d, bo, bb);
    check("post_abort_diff", {24'b0, d}, 32'h1E);
    check("post_abort_bout", {31'b0, bo}, 0);
    check("post_abort_lat", lat, 9);

    // random sweeps against (a-b) mod 2^W and a<b
    for (int i = 0; i < 1000; i++) begin
      ma = $urandom & 32'h1;
      mb = $urandom & 32'h1;
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = ma[0]; bus1.b = mb[0];
      @(negedge clk);
      bus1.start = 1'b0;
      lat = 1;
      while (!bus1.done && lat < 40) begin @(negedge clk); lat++; end
      check("sw1_latency", lat, 2);
      check("sw1_diff", {31'b0, bus1.diff}, (ma - mb) & 32'h1);
      check("sw1_bout", {31'b0, bus1.bout}, {31'b0, ma < mb});
    end

    for (int i = 0; i < 1000; i++) begin
      ma = $urandom & 32'hFF;
      mb = $urandom & 32'hFF;
      job8(ma[7:0], mb[7:0], lat, d, bo, bb);
      check("sw8_latency", lat, 9);
      check("sw8_diff", {24'b0, d}, (ma - mb) & 32'hFF);
      check("sw8_bout", {31'b0, bo}, {31'b0, ma < mb});
    end

    for (int i = 0; i < 1000; i++) begin
      ma = $urandom & 32'h1FFF;
      mb = $urandom & 32'h1FFF;
      @(negedge clk);
      bus13.start = 1'b1; bus13.a = ma[12:0]; bus13.b = mb[12:0];
      @(negedge clk);
      bus13.start = 1'b0;
      lat = 1;
      while (!bus13.done && lat < 40) begin @(negedge clk); lat++; end
      check("sw13_latency", lat, 14);
      check("sw13_diff", {19'b0, bus13.diff}, (ma - mb) & 32'h1FFF);
      check("sw13_bout", {31'b0, bus13.bout}, {31'b0, ma < mb});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Bit-serial unsigned subtractor computing `diff = a - b` over `WIDTH` bits, one bit per clock, LSB first. It feeds the operand pair bit by bit through the team's single-bit `full_sub` cell and registers the borrow between bits. It sits downstream of the operand source and upstream of any consumer needing the difference and the final borrow. Area is traded for latency: one subtractor cell replaces a `WIDTH`-bit ripple chain.

## Interface
- `WIDTH`, default 8, operand and result width in bits; legal range is 1 or more.
- `clk`  in  1  single clock; every register updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request to begin a subtraction; sampled only in IDLE or DONE.
- `a`  in  WIDTH  minuend; captured in the cycle `start` is accepted.
- `b`  in  WIDTH  subtrahend; captured in the same cycle as `a`.
- `busy`  out  1  high while a subtraction is in RUN.
- `done`  out  1  one-cycle pulse; `diff` and `bout` are valid from this cycle.
- `diff`  out  WIDTH  result `(a - b) mod 2^WIDTH`; held until the next `done`.
- `bout`  out  1  final borrow; 1 if and only if `a < b` (unsigned); held until the next `done`.

## Operation
- States:
  - IDLE: waiting for work.
  - RUN: performing bit-serial subtraction.
  - DONE: result presentation, lasting exactly one cycle.
- Reset: state IDLE; `busy`, `done`, `diff`, `bout`, the internal shift registers, the borrow flop and the bit counter are all 0.
- IDLE with `start`=1:
  - load `a` into shift register SA and `b` into SB;
  - clear the borrow flop and the result shift register;
  - set counter to 0;
  - go to RUN.
- IDLE with `start`=0: remain in IDLE.
- RUN, each cycle:
  - the bit slice computes `d = SA[0] ^ SB[0] ^ brw` and `bo = (~SA[0] & SB[0]) | (~(SA[0]^SB[0]) & brw)`;
  - SA and SB shift right by one;
  - `d` shifts into the MSB of the result register, which shifts right;
  - `brw <= bo`;
  - counter increments.
- RUN exit: on the cycle where the counter equals `WIDTH-1`, the next state is DONE. In that same edge, the final shifted result is copied to `diff` and the final `bo` to `bout`.
- DONE:
  - `done`=1 for exactly one cycle;
  - `start`=1 accepts a new job with the same load actions as IDLE and goes to RUN (back-to-back operation);
  - `start`=0 goes to IDLE.
- `start` asserted in RUN is ignored and not queued. Operands are not re-sampled during RUN.
- `diff` and `bout` change only on entry to DONE or on reset.
- Reset mid-operation: return to IDLE with all outputs 0. The aborted job never produces `done`.
- Counter width is `$clog2(WIDTH+1)`. With `WIDTH`=1, RUN lasts one cycle.

## Timing
- `start` accepted in cycle 0 → `busy`=1 in cycles 1 to `WIDTH` → `done`=1 in cycle `WIDTH+1`.
- Latency is `WIDTH+1` cycles from accepted `start` to `done`.
- Throughput is one result every `WIDTH+1` cycles when `start` is asserted during each DONE cycle.
- `busy` and `done` are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `serial_sub_pkg`:
  - state enum `sub_state_t` with values `IDLE`, `RUN`, `DONE`;
  - constant `SUB_DEFAULT_WIDTH = 8`.
- Sub-module: one instance of the existing `full_sub` cell as the combinational bit slice, with ports `a=SA[0]`, `b=SB[0]`, `bi=brw`, `d`, `bo`. No new sub-module is required.
- Top level contains the FSM, the counter, the SA/SB/result shift registers, the borrow flop and the output registers.

## Test plan
- `WIDTH`=8, `a`=0x5A, `b`=0x3C, pulse `start` → `done` in cycle 9 with `diff`=0x1E and `bout`=0; `busy` high in cycles 1 to 8 only.
- `a`=0x00, `b`=0x01 → `diff`=0xFF, `bout`=1. Also `a`=0xFF, `b`=0xFF → `diff`=0x00, `bout`=0.
- `start` pulsed again in cycle 4 with `a`=0x11, `b`=0x22 during a 0x5A−0x3C job → ignored; result stays 0x1E/0; there is no extra `done`.
- `start` held high continuously with new operands presented in each DONE cycle:
  - 0x10−0x01 gives 0x0F/0;
  - then 0x01−0x10 gives 0xF1/1;
  - `done` pulses exactly every 9 cycles.
- `rst` asserted in cycle 5 of a job → IDLE next cycle; `diff`, `bout`, `busy` and `done` are 0; no `done` appears for the aborted job; a subsequent job completes correctly.
- Random sweep at `WIDTH`=1, 8 and 13, with 1000 operand pairs each, checked against a reference model `diff=(a-b)` mod `2^WIDTH`, `bout=(a<b)`.
